// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte capture into a first-word-fall-through FIFO with overflow status
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              rx_clear,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_WAIT, S_ACK} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  assign out_valid = (level != '0);
  assign full      = (level == FULL_LEVEL);
  assign out_data  = mem[rd_ptr];

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_req = (state == S_WAIT) && rx_done;
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      rx_clear <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (rx_done) begin
            rx_clear <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (!rx_done) begin
            rx_clear <= 1'b0;
            state    <= S_WAIT;
          end
        end
        default: begin
          rx_clear <= 1'b0;
          state    <= S_WAIT;
        end
      endcase

      if (push_ok) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      case ({push_ok, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase

      // A fresh drop outranks a clear request in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table and sequence checks for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_clear;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       full;
  logic       overflow;
  logic       overflow_clr;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_clear(rx_clear),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .full(full),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] data;
    logic       done;
    logic       ready;
    logic       oclr;
    logic       e_clear;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [7:0] data, input logic done,
                         input logic ready, input logic oclr, input logic e_clear,
                         input logic e_valid, input logic [7:0] e_data,
                         input logic [4:0] e_level, input logic e_full, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.data = data; v.done = done; v.ready = ready; v.oclr = oclr;
    v.e_clear = e_clear; v.e_valid = e_valid; v.e_data = e_data;
    v.e_level = e_level; v.e_full = e_full; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle receiver handshake: done high for one cycle, then low.
  task automatic send_byte(input logic [7:0] b, input string tag);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    chk({tag, " clear_rise"}, rx_clear, 1'b1);
    rx_done = 1'b0;
    tick();
    chk({tag, " clear_fall"}, rx_clear, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_done = 1'b0;
    out_ready = 1'b0;
    overflow_clr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain_expect(input logic [7:0] first, input int n, input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, " valid"}, out_valid, 1'b1);
      chk({tag, " data"}, out_data, first + 8'(i));
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    out_ready = 1'b0;
    overflow_clr = 1'b0;

    //      rst data   done rdy clr | clear valid data  lvl full ovf
    add_vec(1, 8'h00, 0, 0, 0,   0, 0, 8'h00, 5'd0, 0, 0);
    add_vec(0, 8'hA5, 1, 0, 0,   1, 1, 8'hA5, 5'd1, 0, 0);
    add_vec(0, 8'hA5, 1, 0, 0,   1, 1, 8'hA5, 5'd1, 0, 0);
    add_vec(0, 8'hA5, 0, 0, 0,   0, 1, 8'hA5, 5'd1, 0, 0);
    add_vec(0, 8'h00, 0, 1, 0,   0, 0, 8'h00, 5'd0, 0, 0);
    add_vec(0, 8'h00, 0, 1, 0,   0, 0, 8'h00, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      add_vec(0, 8'h3C, 1, 0, 0, 1, 1, 8'h3C, 5'd1, 0, 0);
    end
    add_vec(0, 8'h3C, 0, 0, 0,   0, 1, 8'h3C, 5'd1, 0, 0);
    add_vec(0, 8'h00, 0, 1, 0,   0, 0, 8'h00, 5'd0, 0, 0);

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      rx_data = vecs[k].data;
      rx_done = vecs[k].done;
      out_ready = vecs[k].ready;
      overflow_clr = vecs[k].oclr;
      tick();
      chk($sformatf("vec%0d rx_clear", k), rx_clear, vecs[k].e_clear);
      chk($sformatf("vec%0d out_valid", k), out_valid, vecs[k].e_valid);
      chk($sformatf("vec%0d level", k), level, vecs[k].e_level);
      chk($sformatf("vec%0d full", k), full, vecs[k].e_full);
      chk($sformatf("vec%0d overflow", k), overflow, vecs[k].e_ovf);
      if (vecs[k].e_valid) begin
        chk($sformatf("vec%0d out_data", k), out_data, vecs[k].e_data);
      end
    end
    out_ready = 1'b0;

    // Fill to DEPTH, then one more byte is dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), "fill");
    end
    chk("fill full", full, 1'b1);
    chk("fill level16", level, 5'd16);
    chk("fill no_ovf", overflow, 1'b0);
    send_byte(8'h10, "drop");
    chk("drop level", level, 5'd16);
    chk("drop ovf", overflow, 1'b1);
    drain_expect(8'h00, 16, "drain");
    chk("drain empty_valid", out_valid, 1'b0);
    chk("drain empty_level", level, 5'd0);
    chk("drain full_low", full, 1'b0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr alone", overflow, 1'b0);

    // Push and pop together while full; then clear-vs-drop priority.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 + 8'(i), "fill2");
    end
    out_ready = 1'b1;
    rx_data = 8'h77;
    rx_done = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop level", level, 5'd16);
    chk("pushpop ovf", overflow, 1'b0);
    chk("pushpop clear", rx_clear, 1'b1);
    rx_done = 1'b0;
    tick();
    rx_data = 8'h99;
    rx_done = 1'b1;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("prio ovf", overflow, 1'b1);
    chk("prio level", level, 5'd16);
    rx_done = 1'b0;
    tick();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("prio clr_alone", overflow, 1'b0);
    drain_expect(8'h41, 15, "drain2");
    out_ready = 1'b1;
    chk("last data", out_data, 8'h77);
    tick();
    out_ready = 1'b0;
    chk("drain2 empty", level, 5'd0);

    // Reset while the capture FSM sits in ACK.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hD0 + 8'(i), "pre");
    end
    rx_data = 8'hD4;
    rx_done = 1'b1;
    tick();
    chk("pre level5", level, 5'd5);
    reset = 1'b1;
    rx_done = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst level", level, 5'd0);
    chk("rst valid", out_valid, 1'b0);
    chk("rst clear", rx_clear, 1'b0);
    send_byte(8'hE1, "post");
    chk("post level", level, 5'd1);
    chk("post data", out_data, 8'hE1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
